fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly downstream of the PC register: takes the current PC, issues a
//  request/ready/rvalid transaction to instruction memory and loads the returned word into the IF/ID register.
//  Generates pc_advance, the PC load enable, so the PC only moves once an instruction has been accepted.
//  Handles decode stall (one-entry hold buffer) and branch/jump flush (NOP injection, late-response discard).
// PARAMETERS
//  ADDR_W    32        address width
//  DATA_W    32        instruction width
//  NOP_INSTR 32'h0     word driven on instr_out when the IF/ID register is invalid or flushed
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous, active-low reset
//  pc_in        in   ADDR_W  current PC from the PC register
//  stall        in   1       decode cannot accept; hold IF/ID contents
//  flush        in   1       redirect; kill IF/ID and any in-flight fetch
//  imem_ready   in   1       memory accepts request this cycle
//  imem_rvalid  in   1       imem_rdata is valid this cycle
//  imem_rdata   in   DATA_W  returned instruction word
//  imem_req     out  1       request valid
//  imem_addr    out  ADDR_W  request address, stable while imem_req=1
//  pc_advance   out  1       one-cycle pulse: PC may load its next address
//  instr_out    out  DATA_W  IF/ID instruction
//  pc4_out      out  ADDR_W  IF/ID PC+4
//  valid_out    out  1       IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; imem_req=0, imem_addr=0, pc_advance=0, instr_out=NOP_INSTR,
//   pc4_out=0, valid_out=0, hold buffer empty, discard flag clear. Reset mid-transaction abandons it.
//  FSM states IDLE, REQ, WAIT, HOLD:
//   IDLE: one cycle after reset release; latch imem_addr<=pc_in; -> REQ.
//   REQ : imem_req=1, imem_addr held. imem_ready=1 -> WAIT (req drops next cycle).
//   WAIT: on imem_rvalid: discard set -> clear discard, latch pc_in, -> REQ (word dropped);
//         else stall=0 -> load IF/ID {rdata, imem_addr+4, valid=1}, pc_advance=1, -> IDLE;
//         else stall=1 -> write hold buffer, -> HOLD.
//   HOLD: stall=0 -> move hold buffer to IF/ID, pc_advance=1, -> IDLE.
//  pc_advance pulse: PC loads new value at the same edge; IDLE then latches the new pc_in next cycle.
//  Latency: IDLE->REQ 1 cycle; with imem_ready in REQ and imem_rvalid on the following cycle, IF/ID
//   loads 3 edges after entering IDLE. Throughput with zero-wait memory: 1 instruction per 3 cycles.
//  stall=1 with no new word: IF/ID holds all fields unchanged.
//  flush (priority over stall): IF/ID valid_out<=0, instr_out<=NOP_INSTR at next edge; hold buffer
//   emptied; in REQ the request completes normally but discard is set; in WAIT without rvalid, discard is set;
//   in WAIT with rvalid the same-cycle word is dropped; HOLD/IDLE -> IDLE. No pc_advance from a flushed fetch.
//  imem_rvalid outside WAIT is ignored. pc4_out arithmetic is modulo 2^ADDR_W (0xFFFFFFFC -> 0x0).
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined: extra output align_fault (1 bit, reset 0). In IDLE, pc_in[1:0]!=0 sets
//   align_fault (sticky until reset), no request is issued, FSM stays IDLE, pc_advance stays 0.
//  Not defined: port absent, pc_in[1:0] ignored, address passed through unchanged.
// STRUCTURE
//  fetch_pkg: state enum (IDLE/REQ/WAIT/HOLD, 2-bit), NOP constant, ADDR_W/DATA_W defaults.
//  Sub-module if_id_reg: IF/ID register with load/hold/flush, async active-low reset; FSM stays in top.
// TESTING
//  1 Reset release, pc_in=0x0, imem_ready=1, rvalid next cycle with 0x2002_0005 -> imem_addr=0x0,
//    instr_out=0x2002_0005, pc4_out=0x4, valid_out=1, single pc_advance pulse.
//  2 imem_ready low 4 cycles in REQ -> imem_req held 1, imem_addr constant, no pc_advance.
//  3 stall=1 when rvalid returns 0xAABB_CCDD -> IF/ID unchanged, FSM HOLD; stall drops ->
//    instr_out=0xAABB_CCDD, one pc_advance.
//  4 flush in WAIT before rvalid, pc_in=0x40 -> late word dropped, valid_out=0, next imem_addr=0x40.
//  5 flush and stall same cycle with valid IF/ID -> valid_out=0, instr_out=NOP_INSTR.
//  6 FETCH_ALIGN_CHECK_EN, pc_in=0x6 -> align_fault=1, imem_req stays 0; assert rst -> align_fault=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;
  localparam int          FETCH_ADDR_W = 32;
  localparam int          FETCH_DATA_W = 32;
  localparam logic [31:0] FETCH_NOP    = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise contents hold.
module if_id_reg #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [ADDR_W-1:0] pc4_in,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc4_out,
  output logic              valid_out
);
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc4_d   = pc4_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_out = instr_q;
  assign pc4_out   = pc4_q;
  assign valid_out = valid_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC -> imem req/ready/rvalid -> IF/ID, with stall hold and flush discard.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky align_fault output for misaligned PCs.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = FETCH_ADDR_W,
  parameter int                DATA_W    = FETCH_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(FETCH_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              stall,
  input  logic              flush,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              pc_advance,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc4_out,
  output logic              valid_out
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              align_fault
`endif
);
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              discard_q, discard_d;
  logic [DATA_W-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0] hold_pc4_q, hold_pc4_d;
  logic              ifid_load;
  logic [DATA_W-1:0] ifid_instr;
  logic [ADDR_W-1:0] pc4;
  logic              misaligned;

  assign pc4 = addr_q + ADDR_W'(4);

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_fault_q, align_fault_d;
  assign misaligned  = |pc_in[1:0];
  assign align_fault = align_fault_q;
  assign align_fault_d = align_fault_q | (state_q == ST_IDLE && !flush && misaligned);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) align_fault_q <= 1'b0;
    else      align_fault_q <= align_fault_d;
  end
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    discard_d    = discard_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    imem_req     = 1'b0;
    pc_advance   = 1'b0;
    ifid_load    = 1'b0;
    ifid_instr   = imem_rdata;
    unique case (state_q)
      ST_IDLE: begin
        if (!flush && !misaligned) begin
          addr_d  = pc_in;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        imem_req = 1'b1;
        // A redirect cannot retract an offered request; the reply is dropped instead.
        if (flush)      discard_d = 1'b1;
        if (imem_ready) state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (discard_q || flush) begin
            discard_d = 1'b0;
            if (flush) begin
              state_d = ST_IDLE;
            end else begin
              addr_d  = pc_in;
              state_d = ST_REQ;
            end
          end else if (!stall) begin
            ifid_load  = 1'b1;
            pc_advance = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc4_d   = pc4;
            state_d      = ST_HOLD;
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (!stall) begin
          ifid_load  = 1'b1;
          ifid_instr = hold_instr_q;
          pc_advance = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      discard_q    <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      hold_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      discard_q    <= discard_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  assign imem_addr = addr_q;

  if_id_reg #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .flush    (flush),
    .instr_in (ifid_instr),
    .pc4_in   ((state_q == ST_HOLD) ? hold_pc4_q : pc4),
    .instr_out(instr_out),
    .pc4_out  (pc4_out),
    .valid_out(valid_out)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios plus a randomized memory/stall run checked against a transaction-level model.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        stall, flush, imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_req, pc_advance, valid_out;
  logic [31:0] imem_addr, instr_out, pc4_out;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        align_fault;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .pc_in      (pc_in),
    .stall      (stall),
    .flush      (flush),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc_advance (pc_advance),
    .instr_out  (instr_out),
    .pc4_out    (pc4_out),
    .valid_out  (valid_out)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .align_fault(align_fault)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic drive_quiet();
    stall = 1'b0; flush = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
  endtask

  // Asserts reset asynchronously, checks the reset image, releases just after an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    drive_quiet();
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_adv", pc_advance, 0);
    check("rst_instr", instr_out, NOP);
    check("rst_pc4", pc4_out, 0);
    check("rst_valid", valid_out, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("rst_align", align_fault, 0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Random-phase model state
  logic [31:0] pc_model, out_addr, comp_addr, exp_instr, exp_pc4;
  logic        exp_valid, outstanding, completed, deliver, exp_adv;
  int          cd, retired;

  task automatic model_clear();
    outstanding = 1'b0; completed = 1'b0; cd = 0;
    exp_instr = NOP; exp_pc4 = '0; exp_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    pc_in = '0;
    drive_quiet();
    #2;
    do_reset();

    // T1: basic fetch
    pc_in = 32'h0; imem_ready = 1'b1;
    #1 check("t1_idle_req", imem_req, 0);
    tick();
    #1 check("t1_req", imem_req, 1);
    check("t1_addr", imem_addr, 32'h0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h2002_0005;
    #1 check("t1_adv", pc_advance, 1);
    check("t1_req_drop", imem_req, 0);
    tick();
    imem_rvalid = 1'b0; pc_in = 32'h4;
    #1 check("t1_instr", instr_out, 32'h2002_0005);
    check("t1_pc4", pc4_out, 32'h4);
    check("t1_valid", valid_out, 1);
    check("t1_adv_once", pc_advance, 0);

    // T2: imem_ready low for four cycles
    imem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1 check("t2_req", imem_req, 1);
      check("t2_addr", imem_addr, 32'h4);
      check("t2_adv", pc_advance, 0);
      tick();
    end
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;

    // T3: stall when the word returns
    stall = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hAABB_CCDD;
    #1 check("t3_adv_stalled", pc_advance, 0);
    tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 check("t3_hold_instr", instr_out, 32'h2002_0005);
      check("t3_hold_pc4", pc4_out, 32'h4);
      check("t3_hold_valid", valid_out, 1);
      check("t3_hold_req", imem_req, 0);
      tick();
    end
    stall = 1'b0;
    #1 check("t3_adv", pc_advance, 1);
    tick();
    pc_in = 32'h8;
    #1 check("t3_instr", instr_out, 32'hAABB_CCDD);
    check("t3_pc4", pc4_out, 32'h8);
    check("t3_adv_once", pc_advance, 0);

    // T4: flush in WAIT before the word returns
    imem_ready = 1'b1;
    tick();
    tick();
    imem_ready = 1'b0; flush = 1'b1; pc_in = 32'h40;
    #1 check("t4_adv_flush", pc_advance, 0);
    tick();
    flush = 1'b0;
    #1 check("t4_valid", valid_out, 0);
    check("t4_instr", instr_out, NOP);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1 check("t4_late_adv", pc_advance, 0);
    tick();
    imem_rvalid = 1'b0;
    #1 check("t4_req", imem_req, 1);
    check("t4_addr", imem_addr, 32'h40);
    check("t4_dropped", valid_out, 0);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
    #1 check("t4_adv", pc_advance, 1);
    tick();
    imem_rvalid = 1'b0; pc_in = 32'h44;
    #1 check("t4_instr2", instr_out, 32'h1111_2222);
    check("t4_pc4", pc4_out, 32'h44);

    // T5: flush and stall together with a valid IF/ID
    flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    #1 check("t5_valid", valid_out, 0);
    check("t5_instr", instr_out, NOP);

    // T6: rvalid outside WAIT ignored; pc4 wraps
    pc_in = 32'hFFFF_FFFC; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D;
    #1 check("t6_idle_rvalid", pc_advance, 0);
    tick();
    #1 check("t6_req_rvalid", pc_advance, 0);
    check("t6_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    imem_rvalid = 1'b0; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_F00D;
    #1 check("t6_adv", pc_advance, 1);
    tick();
    imem_rvalid = 1'b0; pc_in = 32'h6;
    #1 check("t6_instr", instr_out, 32'h0BAD_F00D);
    check("t6_pc4_wrap", pc4_out, 32'h0);
    check("t6_ignored", valid_out, 1);

    // T7: misaligned PC
    tick();
`ifdef FETCH_ALIGN_CHECK_EN
    #1 check("t7_fault", align_fault, 1);
    check("t7_req", imem_req, 0);
    tick();
    #1 check("t7_req_stay", imem_req, 0);
    check("t7_adv", pc_advance, 0);
    do_reset();
    #1 check("t7_fault_clr", align_fault, 0);
`else
    #1 check("t7_passthru", imem_addr, 32'h6);
    check("t7_req", imem_req, 1);
    imem_ready = 1'b1;
    tick();
    do_reset();
`endif

    // Randomized phase; a reset lands mid-run to abandon whatever is in flight
    do_reset();
    model_clear();
    retired = 0;
    pc_model = 32'hFFFF_FFE0;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        do_reset();
        model_clear();
      end
      stall = ($urandom % 4) == 0;
      imem_ready = $urandom % 2;
      flush = 1'b0;
      deliver = outstanding && (cd == 0);
      if (deliver) begin
        imem_rvalid = 1'b1; imem_rdata = mem_word(out_addr);
      end else if (!outstanding && ($urandom % 6) == 0) begin
        imem_rvalid = 1'b1; imem_rdata = $urandom;
      end else begin
        imem_rvalid = 1'b0; imem_rdata = $urandom;
      end
      pc_in = pc_model;
      #1;
      exp_adv = !stall && (completed || deliver);
      check("r_adv", pc_advance, exp_adv);
      if (imem_req) begin
        check("r_req_addr", imem_addr, pc_model);
        check("r_req_busy", outstanding || completed, 0);
      end
      check("r_instr", instr_out, exp_instr);
      check("r_pc4", pc4_out, exp_pc4);
      check("r_valid", valid_out, exp_valid);
      if (deliver) begin
        outstanding = 1'b0; completed = 1'b1; comp_addr = out_addr;
      end else if (outstanding) begin
        cd--;
      end
      if (exp_adv) begin
        exp_instr = mem_word(comp_addr);
        exp_pc4   = comp_addr + 32'd4;
        exp_valid = 1'b1;
        completed = 1'b0;
        retired++;
        pc_model = (($urandom % 4) == 0) ? ($urandom & 32'hFFFF_FFFC) : pc_model + 32'd4;
      end
      if (imem_req && imem_ready) begin
        outstanding = 1'b1; out_addr = imem_addr; cd = $urandom % 3;
      end
      tick();
    end
    check("r_progress", retired > 40, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
